// File: rtl/pe_uno_seq.sv
// Sequencer for one column of unary-mode PEs: accepts (mode, len) commands, streams x operands,
// drives per-stage coefficients from a programmable table and returns one result per operand.
module pe_uno_seq #(
  parameter int N_PE   = 4,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int LEN_BW = 8,
  localparam int IDX_BW = $clog2(N_PE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [LEN_BW-1:0]      cmd_len,
  output logic                   cmd_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MUL_BW-1:0]      in_x,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_mode,
  input  logic [IDX_BW-1:0]      cfg_idx,
  input  logic [MUL_BW-1:0]      cfg_data,
  output logic                   cfg_err,
  output logic [1:0]             pe_mode,
  output logic [ACC_BW-1:0]      pe_mac,
  output logic [MUL_BW-1:0]      pe_var,
  output logic [N_PE*MUL_BW-1:0] pe_wc,
  input  logic [ACC_BW-1:0]      pe_o,
  output logic                   res_valid,
  output logic [ACC_BW-1:0]      res_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [IDX_BW-1:0] IDX_MAX = IDX_BW'(N_PE);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [LEN_BW-1:0] rem_q, rem_d;
  logic [N_PE:0]     vld_q;
  logic              cmd_err_q, cfg_err_q;
  logic [MUL_BW-1:0] tbl_q [4][N_PE+1];

  logic cmd_hs, cmd_legal, in_hs, cfg_ok;
  logic drive_mode, drive_coef;
  logic [ACC_BW-1:0] mac_ext;

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign cmd_legal = (cmd_mode != 2'b00) && (cmd_len != '0);
  assign in_hs     = in_valid & in_ready;
  // A write that lands on the same cycle as a command handshake is refused so the command sees the old table.
  assign cfg_ok    = cfg_we && (state_q == S_IDLE) && (cfg_mode != 2'b00) &&
                     (cfg_idx <= IDX_MAX) && !cmd_hs;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_legal) begin
          state_d = S_LOAD;
          mode_d  = cmd_mode;
          rem_d   = cmd_len;
        end
      end
      S_LOAD: state_d = S_STREAM;
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rem_d = rem_q - LEN_BW'(1);
          if (rem_q == LEN_BW'(1)) state_d = S_DRAIN;
        end
      end
      // Leave one cycle early: the entry in the top slot is the last result and retires this cycle.
      S_DRAIN: if (vld_q[N_PE-1:0] == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      rem_q     <= '0;
      vld_q     <= '0;
      cmd_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      vld_q     <= {vld_q[N_PE-1:0], in_hs};
      cmd_err_q <= cmd_hs & ~cmd_legal;
      cfg_err_q <= cfg_we & ~cfg_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '{default: '0};
    end else if (cfg_ok) begin
      tbl_q[cfg_mode][cfg_idx] <= cfg_data;
    end
  end

  assign drive_mode = (state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign drive_coef = drive_mode || (state_q == S_DONE);

  assign pe_mode = drive_mode ? mode_q : 2'b00;
  assign mac_ext = ACC_BW'($signed(tbl_q[mode_q][N_PE]));
  assign pe_mac  = drive_coef ? (mac_ext << MUL_BW) : '0;
  assign pe_var  = in_hs ? in_x : '0;

  // Stage k consumes the coefficients in descending order, starting just below the mac seed.
  for (genvar g = 0; g < N_PE; g++) begin : g_wc
    assign pe_wc[g*MUL_BW +: MUL_BW] = drive_coef ? tbl_q[mode_q][N_PE-1-g] : '0;
  end

  assign res_valid = vld_q[N_PE];
  assign res_data  = res_valid ? pe_o : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cmd_err   = cmd_err_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pe_uno_seq.sv
// Directed bench for pe_uno_seq with a behavioural PE column model and a Horner golden model.
module tb_pe_uno_seq;
  localparam int N_PE   = 4;
  localparam int MUL_BW = 16;
  localparam int ACC_BW = 32;
  localparam int LEN_BW = 8;
  localparam int IDX_BW = $clog2(N_PE + 1);
  localparam int LAT    = N_PE + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [1:0]             cmd_mode = '0;
  logic [LEN_BW-1:0]      cmd_len = '0;
  logic                   cmd_err;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [MUL_BW-1:0]      in_x = '0;
  logic                   cfg_we = 1'b0;
  logic [1:0]             cfg_mode = '0;
  logic [IDX_BW-1:0]      cfg_idx = '0;
  logic [MUL_BW-1:0]      cfg_data = '0;
  logic                   cfg_err;
  logic [1:0]             pe_mode;
  logic [ACC_BW-1:0]      pe_mac;
  logic [MUL_BW-1:0]      pe_var;
  logic [N_PE*MUL_BW-1:0] pe_wc;
  logic [ACC_BW-1:0]      pe_o;
  logic                   res_valid;
  logic [ACC_BW-1:0]      res_data;
  logic                   busy;
  logic                   done;

  always #5 clk = ~clk;

  pe_uno_seq #(.N_PE(N_PE), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .LEN_BW(LEN_BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_err(cfg_err),
    .pe_mode(pe_mode), .pe_mac(pe_mac), .pe_var(pe_var), .pe_wc(pe_wc), .pe_o(pe_o),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PE column: each stage does acc = acc*var + (wc << MUL_BW); one cycle per stage plus input register.
  function automatic logic [ACC_BW-1:0] col_eval(input logic [ACC_BW-1:0] mac,
                                                 input logic [N_PE*MUL_BW-1:0] wc,
                                                 input logic [MUL_BW-1:0] v);
    logic [ACC_BW-1:0] a;
    a = mac;
    for (int k = 0; k < N_PE; k++)
      a = a * ACC_BW'(v) + (ACC_BW'(wc[k*MUL_BW +: MUL_BW]) << MUL_BW);
    return a;
  endfunction

  logic [ACC_BW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= col_eval(pe_mac, pe_wc, pe_var);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pe_o = pipe[LAT-1];

  logic [MUL_BW-1:0] tbm [4][N_PE+1];

  function automatic logic [ACC_BW-1:0] golden(input logic [1:0] m, input logic [MUL_BW-1:0] x);
    logic [ACC_BW-1:0] a;
    a = ACC_BW'(tbm[m][N_PE]) << MUL_BW;
    for (int j = N_PE - 1; j >= 0; j--)
      a = a * ACC_BW'(x) + (ACC_BW'(tbm[m][j]) << MUL_BW);
    return a;
  endfunction

  int                res_cyc[$];
  logic [ACC_BW-1:0] res_dat[$];
  int                hs_cyc[$];
  logic [1:0]        mode_seq[$];
  logic [1:0]        mode_prev = '0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                cfg_err_cnt = 0;

  always @(negedge clk) begin
    if (res_valid) begin
      res_cyc.push_back(cyc);
      res_dat.push_back(res_data);
    end
    if (in_valid && in_ready) hs_cyc.push_back(cyc);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cfg_err) cfg_err_cnt <= cfg_err_cnt + 1;
    if (pe_mode != mode_prev) begin
      mode_seq.push_back(pe_mode);
      mode_prev <= pe_mode;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] m, input logic [IDX_BW-1:0] i, input logic [MUL_BW-1:0] d);
    cfg_we = 1'b1; cfg_mode = m; cfg_idx = i; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [LEN_BW-1:0] l, output int hc);
    cmd_valid = 1'b1; cmd_mode = m; cmd_len = l; hc = -1;
    for (int n = 0; n < 200; n++) begin
      if (cmd_ready) begin
        hc = cyc;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(hc >= 0), 64'd1);
  endtask

  // With gaps the operand is offered every other cycle, starting on the first STREAM cycle.
  task automatic stream(input int n, input bit gaps, input logic [MUL_BW-1:0] x0);
    int k = 0;
    for (int c = 0; c < 400 && k < n; c++) begin
      in_valid = !gaps || (c % 2 == 1);
      in_x     = x0 + MUL_BW'(k);
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    in_x     = '0;
    check("stream_accepted", 64'(k), 64'(n));
  endtask

  task automatic wait_done(input int prev);
    for (int n = 0; n < 100 && done_cnt == prev; n++) tick();
    check("done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic run_cmd(input logic [1:0] m, input int n, input bit gaps, input logic [MUL_BW-1:0] x0,
                         input bit clash_cmd, input bit clash_mid, output int hc);
    int d0, e0, last;
    logic [ACC_BW-1:0] emac;
    res_cyc.delete(); res_dat.delete(); hs_cyc.delete();
    d0 = done_cnt;
    e0 = cfg_err_cnt;
    if (clash_cmd) begin
      cfg_we = 1'b1; cfg_mode = 2'b10; cfg_idx = '0; cfg_data = 16'h7FFF;
    end
    send_cmd(m, LEN_BW'(n), hc);
    cfg_we = 1'b0;
    emac = ACC_BW'(tbm[m][N_PE]) << MUL_BW;
    check("load_mode", 64'(pe_mode), 64'(m));
    check("load_busy", 64'(busy), 64'd1);
    check("load_cmd_ready", 64'(cmd_ready), 64'd0);
    check("load_mac", 64'(pe_mac), 64'(emac));
    for (int k = 0; k < N_PE; k++)
      check($sformatf("load_wc%0d", k), 64'(pe_wc[k*MUL_BW +: MUL_BW]), 64'(tbm[m][N_PE-1-k]));
    if (clash_mid) begin
      fork
        stream(n, gaps, x0);
        begin
          tick();
          cfg_write(2'b10, IDX_BW'(2), 16'h7FFF);
        end
      join
    end else begin
      stream(n, gaps, x0);
    end
    wait_done(d0);
    repeat (3) tick();
    check("res_count", 64'(res_dat.size()), 64'(n));
    check("done_count", 64'(done_cnt), 64'(d0 + 1));
    check("hs_first", 64'(hs_cyc.size() > 0 ? hs_cyc[0] : -1), 64'(hc + 2));
    for (int i = 0; i < n && i < res_dat.size() && i < hs_cyc.size(); i++) begin
      check($sformatf("res_data%0d", i), 64'(res_dat[i]), 64'(golden(m, x0 + MUL_BW'(i))));
      check($sformatf("res_lat%0d", i), 64'(res_cyc[i] - hs_cyc[i]), 64'(LAT));
      if (i > 0) check($sformatf("hs_gap%0d", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(gaps ? 2 : 1));
    end
    last = res_cyc.size() > 0 ? res_cyc[res_cyc.size()-1] : -10;
    check("done_after_last", 64'(done_cyc), 64'(last + 1));
    check("end_busy", 64'(busy), 64'd0);
    check("end_mode", 64'(pe_mode), 64'd0);
    check("cfg_err_cnt", 64'(cfg_err_cnt), 64'(e0 + ((clash_cmd || clash_mid) ? 1 : 0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, h1, h2, d0, d1, rc;
    tbm = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", 64'({in_ready, res_valid, done, cmd_err, cfg_err, pe_mode}), 64'd0);
    check("rst_pe_mac", 64'(pe_mac), 64'd0);
    check("rst_pe_wc", 64'(pe_wc), 64'd0);
    rst_n = 1'b1;
    tick();

    // Illegal commands are consumed and flagged without leaving IDLE.
    send_cmd(2'b00, 8'd4, hc);
    check("ill_mode_err", 64'(cmd_err), 64'd1);
    check("ill_mode_busy", 64'(busy), 64'd0);
    tick();
    check("ill_mode_err_end", 64'(cmd_err), 64'd0);
    send_cmd(2'b10, 8'd0, hc);
    check("ill_len_err", 64'(cmd_err), 64'd1);
    check("ill_len_busy", 64'(busy), 64'd0);
    tick();
    check("ill_len_err_end", 64'(cmd_err), 64'd0);

    for (int i = 0; i <= N_PE; i++) begin
      cfg_write(2'b10, IDX_BW'(i), MUL_BW'(i + 1));
      tbm[2][i] = MUL_BW'(i + 1);
      check("cfg_ok_err", 64'(cfg_err), 64'd0);
    end
    cfg_write(2'b10, IDX_BW'(N_PE + 1), 16'h1234);
    check("cfg_idx_err", 64'(cfg_err), 64'd1);
    cfg_write(2'b00, IDX_BW'(1), 16'h1234);
    check("cfg_mode_err", 64'(cfg_err), 64'd1);
    tick();
    check("cfg_err_end", 64'(cfg_err), 64'd0);

    run_cmd(2'b10, 8, 1'b0, 16'd1, 1'b0, 1'b0, hc);
    run_cmd(2'b10, 8, 1'b1, 16'd9, 1'b0, 1'b0, hc);
    run_cmd(2'b10, 2, 1'b1, 16'd3, 1'b0, 1'b1, hc);
    run_cmd(2'b10, 2, 1'b0, 16'd5, 1'b1, 1'b0, hc);

    // Back-to-back: second command waits for the first to finish.
    mode_seq.delete();
    d0 = done_cnt;
    send_cmd(2'b01, 8'd2, h1);
    fork
      send_cmd(2'b11, 8'd3, h2);
      stream(2, 1'b0, 16'd3);
    join
    d1 = done_cyc;
    check("b2b_done1", 64'(done_cnt), 64'(d0 + 1));
    check("b2b_cmd2_after_done", 64'(h2), 64'(d1 + 1));
    stream(3, 1'b0, 16'd4);
    wait_done(d0 + 1);
    tick();
    check("b2b_mode_cnt", 64'(mode_seq.size()), 64'd4);
    if (mode_seq.size() == 4) begin
      check("b2b_mode0", 64'(mode_seq[0]), 64'd1);
      check("b2b_mode1", 64'(mode_seq[1]), 64'd0);
      check("b2b_mode2", 64'(mode_seq[2]), 64'd3);
      check("b2b_mode3", 64'(mode_seq[3]), 64'd0);
    end

    // Reset in the middle of a stream drops in-flight results and the pending done.
    send_cmd(2'b10, 8'd8, hc);
    stream(3, 1'b0, 16'd2);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    tbm = '{default: '0};
    tick();
    rst_n = 1'b1;
    rc = cyc;
    run_cmd(2'b10, 1, 1'b0, 16'd7, 1'b0, 1'b0, hc);
    check("mid_rst_new_cmd", 64'(hc), 64'(rc));
    check("mid_rst_done_total", 64'(done_cnt), 64'(d0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
